// File: rtl/pa_tcipif_pkg.sv
// Shared encodings and address slices for the multi-slave TCIP bus interface.
package pa_tcipif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } tcip_state_e;

  localparam int WIN_W   = 16;
  localparam int WIN_LSB = 12;
  localparam int WIN_MSB = 27;
  localparam int RGN_LSB = 28;
  localparam int RGN_MSB = 31;
  localparam int RGN_W   = RGN_MSB - RGN_LSB + 1;

  // A mask bit of 1 means the corresponding address bit takes part in the compare.
  function automatic logic win_match(input logic [WIN_W-1:0] addr_bits,
                                     input logic [WIN_W-1:0] base_bits,
                                     input logic [WIN_W-1:0] mask_bits);
    return ((addr_bits ^ base_bits) & mask_bits) == '0;
  endfunction

endpackage

// File: rtl/pa_tcipif_win_dec.sv
// Window decoder: per-slave masked compare inside the TCIP region, lowest index wins.
module pa_tcipif_win_dec
  import pa_tcipif_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int IDX_W   = 2
) (
  input  logic [RGN_W-1:0]         rgn_base,
  input  logic [RGN_W-1:0]         rgn_addr,
  input  logic [WIN_W-1:0]         win_addr,
  input  logic [NUM_SLV*WIN_W-1:0] slv_win_base,
  input  logic [NUM_SLV*WIN_W-1:0] slv_win_mask,
  output logic                     hit,
  output logic [IDX_W-1:0]         idx,
  output logic [NUM_SLV-1:0]       onehot
);

  logic               rgn_hit;
  logic [NUM_SLV-1:0] win_hit;

  assign rgn_hit = (rgn_addr == rgn_base);

  always_comb begin
    win_hit = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      win_hit[i] = rgn_hit && win_match(win_addr,
                                        slv_win_base[i*WIN_W +: WIN_W],
                                        slv_win_mask[i*WIN_W +: WIN_W]);
    end
  end

  // Overlapping windows resolve to the lowest slave index.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (win_hit[i] && !hit) begin
        hit       = 1'b1;
        idx       = IDX_W'(i);
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pa_tcipif_nslv_bus.sv
// TCIP bus interface with NUM_SLV programmable windows, privilege check and per-transaction timeout.
module pa_tcipif_nslv_bus
  import pa_tcipif_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int TO_W    = 8,
  parameter int OFF_W   = 16
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst_b,
  input  logic [31:0]              pad_cpu_tcip_base,
  input  logic [NUM_SLV*WIN_W-1:0] slv_win_base,
  input  logic [NUM_SLV*WIN_W-1:0] slv_win_mask,
  input  logic [NUM_SLV-1:0]       slv_user_en,
  input  logic                     bmu_tcipif_dbus_req,
  input  logic [31:0]              bmu_tcipif_dbus_addr,
  input  logic                     bmu_tcipif_dbus_write,
  input  logic [1:0]               bmu_tcipif_dbus_size,
  input  logic [31:0]              bmu_tcipif_dbus_wdata,
  input  logic                     bmu_tcipif_dbus_supv_mode,
  input  logic                     bmu_tcipif_dbus_acc_deny,
  input  logic                     rtu_yy_xx_dbgon,
  input  logic [NUM_SLV-1:0]       slv_tcipif_cmplt,
  input  logic [NUM_SLV*32-1:0]    slv_tcipif_rdata,
  output logic [NUM_SLV-1:0]       tcipif_slv_sel,
  output logic [OFF_W-1:0]         tcipif_xx_addr,
  output logic                     tcipif_xx_write,
  output logic [1:0]               tcipif_xx_size,
  output logic [31:0]              tcipif_xx_wdata,
  output logic                     tcipif_bmu_dbus_grnt,
  output logic                     tcipif_bmu_dbus_trans_cmplt,
  output logic                     tcipif_bmu_dbus_acc_err,
  output logic [31:0]              tcipif_bmu_dbus_data
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [TO_W-1:0] CNT_MAX  = '1;
  localparam logic [TO_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

  tcip_state_e        state_q, state_d;
  logic [NUM_SLV-1:0] sel_q, sel_d;
  logic               err_q, err_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic [OFF_W-1:0]   addr_q;
  logic               write_q;
  logic [1:0]         size_q;
  logic [31:0]        wdata_q;
  logic               latch_en;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic [NUM_SLV-1:0] dec_onehot;
  logic               user_ok;
  logic               err_pre;
  logic               slv_done;
  logic               to_expire;
  logic [31:0]        rd_sel;
  logic               unused_base;

  assign unused_base = ^pad_cpu_tcip_base[RGN_LSB-1:0];

  pa_tcipif_win_dec #(
    .NUM_SLV (NUM_SLV),
    .IDX_W   (IDX_W)
  ) u_win_dec (
    .rgn_base     (pad_cpu_tcip_base[RGN_MSB:RGN_LSB]),
    .rgn_addr     (bmu_tcipif_dbus_addr[RGN_MSB:RGN_LSB]),
    .win_addr     (bmu_tcipif_dbus_addr[WIN_MSB:WIN_LSB]),
    .slv_win_base (slv_win_base),
    .slv_win_mask (slv_win_mask),
    .hit          (dec_hit),
    .idx          (dec_idx),
    .onehot       (dec_onehot)
  );

  assign tcipif_bmu_dbus_grnt = bmu_tcipif_dbus_req && (state_q == ST_IDLE);

  // Debug mode and supervisor mode both bypass the per-slave user enable; PMP deny never does.
  assign user_ok = dec_hit && slv_user_en[dec_idx];
  assign err_pre = bmu_tcipif_dbus_acc_deny ||
                   (!bmu_tcipif_dbus_supv_mode && !rtu_yy_xx_dbgon && !user_ok);

  // Only the selected slave can finish the transfer; stray or late completions are masked here.
  assign slv_done  = |(sel_q & slv_tcipif_cmplt);
  assign to_expire = (cnt_q == CNT_LAST);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) begin
        rd_sel = rd_sel | slv_tcipif_rdata[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        addr_q  <= bmu_tcipif_dbus_addr[OFF_W-1:0];
        write_q <= bmu_tcipif_dbus_write;
        size_q  <= bmu_tcipif_dbus_size;
        wdata_q <= bmu_tcipif_dbus_wdata;
      end
    end
  end

  always_comb begin
    state_d                     = state_q;
    sel_d                       = sel_q;
    err_d                       = err_q;
    cnt_d                       = cnt_q;
    latch_en                    = 1'b0;
    tcipif_bmu_dbus_trans_cmplt = 1'b0;
    tcipif_bmu_dbus_acc_err     = 1'b0;
    tcipif_bmu_dbus_data        = '0;
    case (state_q)
      ST_IDLE: begin
        if (tcipif_bmu_dbus_grnt) begin
          if (err_pre) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else if (dec_hit) begin
            state_d  = ST_BUSY;
            sel_d    = dec_onehot;
            cnt_d    = '0;
            latch_en = 1'b1;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = (cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
        // A completion arriving in the expiry cycle still counts as a normal completion.
        if (slv_done) begin
          state_d                     = ST_IDLE;
          sel_d                       = '0;
          tcipif_bmu_dbus_trans_cmplt = 1'b1;
          tcipif_bmu_dbus_data        = rd_sel;
        end else if (to_expire) begin
          state_d = ST_RESP;
          sel_d   = '0;
          err_d   = 1'b1;
        end
      end
      ST_RESP: begin
        state_d                     = ST_IDLE;
        err_d                       = 1'b0;
        tcipif_bmu_dbus_trans_cmplt = 1'b1;
        tcipif_bmu_dbus_acc_err     = err_q;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  assign tcipif_slv_sel  = sel_q;
  assign tcipif_xx_addr  = addr_q;
  assign tcipif_xx_write = write_q;
  assign tcipif_xx_size  = size_q;
  assign tcipif_xx_wdata = wdata_q;

endmodule

// File: tb/tb_pa_tcipif_nslv_bus.sv
// Scoreboard bench: a reference decode/privilege/timeout model predicts each completion, a monitor checks it.
module tb_pa_tcipif_nslv_bus;

  localparam int NUM_SLV = 4;
  localparam int TO_W    = 4;
  localparam int OFF_W   = 16;
  localparam int TIMEOUT = (1 << TO_W) - 1;

  logic                    forever_cpuclk = 1'b0;
  logic                    cpurst_b = 1'b0;
  logic [31:0]             pad_cpu_tcip_base;
  logic [NUM_SLV*16-1:0]   slv_win_base;
  logic [NUM_SLV*16-1:0]   slv_win_mask;
  logic [NUM_SLV-1:0]      slv_user_en;
  logic                    bmu_tcipif_dbus_req;
  logic [31:0]             bmu_tcipif_dbus_addr;
  logic                    bmu_tcipif_dbus_write;
  logic [1:0]              bmu_tcipif_dbus_size;
  logic [31:0]             bmu_tcipif_dbus_wdata;
  logic                    bmu_tcipif_dbus_supv_mode;
  logic                    bmu_tcipif_dbus_acc_deny;
  logic                    rtu_yy_xx_dbgon;
  logic [NUM_SLV-1:0]      slv_tcipif_cmplt;
  logic [NUM_SLV*32-1:0]   slv_tcipif_rdata;
  logic [NUM_SLV-1:0]      tcipif_slv_sel;
  logic [OFF_W-1:0]        tcipif_xx_addr;
  logic                    tcipif_xx_write;
  logic [1:0]              tcipif_xx_size;
  logic [31:0]             tcipif_xx_wdata;
  logic                    tcipif_bmu_dbus_grnt;
  logic                    tcipif_bmu_dbus_trans_cmplt;
  logic                    tcipif_bmu_dbus_acc_err;
  logic [31:0]             tcipif_bmu_dbus_data;

  pa_tcipif_nslv_bus #(
    .NUM_SLV (NUM_SLV),
    .TO_W    (TO_W),
    .OFF_W   (OFF_W)
  ) dut (
    .forever_cpuclk              (forever_cpuclk),
    .cpurst_b                    (cpurst_b),
    .pad_cpu_tcip_base           (pad_cpu_tcip_base),
    .slv_win_base                (slv_win_base),
    .slv_win_mask                (slv_win_mask),
    .slv_user_en                 (slv_user_en),
    .bmu_tcipif_dbus_req         (bmu_tcipif_dbus_req),
    .bmu_tcipif_dbus_addr        (bmu_tcipif_dbus_addr),
    .bmu_tcipif_dbus_write       (bmu_tcipif_dbus_write),
    .bmu_tcipif_dbus_size        (bmu_tcipif_dbus_size),
    .bmu_tcipif_dbus_wdata       (bmu_tcipif_dbus_wdata),
    .bmu_tcipif_dbus_supv_mode   (bmu_tcipif_dbus_supv_mode),
    .bmu_tcipif_dbus_acc_deny    (bmu_tcipif_dbus_acc_deny),
    .rtu_yy_xx_dbgon             (rtu_yy_xx_dbgon),
    .slv_tcipif_cmplt            (slv_tcipif_cmplt),
    .slv_tcipif_rdata            (slv_tcipif_rdata),
    .tcipif_slv_sel              (tcipif_slv_sel),
    .tcipif_xx_addr              (tcipif_xx_addr),
    .tcipif_xx_write             (tcipif_xx_write),
    .tcipif_xx_size              (tcipif_xx_size),
    .tcipif_xx_wdata             (tcipif_xx_wdata),
    .tcipif_bmu_dbus_grnt        (tcipif_bmu_dbus_grnt),
    .tcipif_bmu_dbus_trans_cmplt (tcipif_bmu_dbus_trans_cmplt),
    .tcipif_bmu_dbus_acc_err     (tcipif_bmu_dbus_acc_err),
    .tcipif_bmu_dbus_data        (tcipif_bmu_dbus_data)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  int cyc = 0;
  always @(posedge forever_cpuclk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_fail = 0;

  bit          resp_busy = 1'b0;
  int          resp_k = 0;
  int          resp_idx = 0;
  int          resp_delay = 1;
  logic [31:0] resp_data = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: completion cycle, error and data follow from decode, privilege and slave delay.
  task automatic modelExpect(input int gcyc, output logic [NUM_SLV-1:0] exp_sel);
    int   hit_idx;
    logic err_pre;
    exp_t e;
    hit_idx = -1;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (hit_idx < 0 && bmu_tcipif_dbus_addr[31:28] == pad_cpu_tcip_base[31:28] &&
          ((bmu_tcipif_dbus_addr[27:12] ^ slv_win_base[i*16 +: 16]) & slv_win_mask[i*16 +: 16]) == 16'h0)
        hit_idx = i;
    end
    err_pre = bmu_tcipif_dbus_acc_deny ||
              (!bmu_tcipif_dbus_supv_mode && !rtu_yy_xx_dbgon &&
               !(hit_idx >= 0 && slv_user_en[hit_idx]));
    exp_sel = '0;
    e.data  = '0;
    e.err   = 1'b0;
    e.cyc   = gcyc + 1;
    if (err_pre) begin
      e.err = 1'b1;
    end else if (hit_idx >= 0) begin
      exp_sel[hit_idx] = 1'b1;
      if (resp_delay <= TIMEOUT) begin
        e.data = resp_data;
        e.cyc  = gcyc + resp_delay;
      end else begin
        e.err = 1'b1;
        e.cyc = gcyc + TIMEOUT + 1;
      end
    end
    sb_q.push_back(e);
  endtask

  // Slave responder: pulses cmplt resp_delay cycles after sel first appears, with junk on other lanes.
  initial begin
    slv_tcipif_cmplt = '0;
    slv_tcipif_rdata = '0;
    forever begin
      @(posedge forever_cpuclk);
      #1;
      slv_tcipif_cmplt = '0;
      if (!cpurst_b) begin
        resp_busy = 1'b0;
      end else begin
        if (!resp_busy && tcipif_slv_sel != '0) begin
          resp_busy = 1'b1;
          resp_k    = 1;
          for (int i = 0; i < NUM_SLV; i++)
            if (tcipif_slv_sel[i]) resp_idx = i;
        end else if (resp_busy) begin
          resp_k++;
        end
        if (resp_busy && resp_k == resp_delay) begin
          for (int i = 0; i < NUM_SLV; i++) slv_tcipif_rdata[i*32 +: 32] = $urandom;
          slv_tcipif_rdata[resp_idx*32 +: 32] = resp_data;
          slv_tcipif_cmplt[resp_idx] = 1'b1;
          resp_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge forever_cpuclk) begin
    if (cpurst_b && tcipif_bmu_dbus_trans_cmplt) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_cmplt", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("cmplt_cycle", 32'(cyc), 32'(mon_e.cyc));
        checkOutput("acc_err", 32'(tcipif_bmu_dbus_acc_err), 32'(mon_e.err));
        checkOutput("rdata", tcipif_bmu_dbus_data, mon_e.data);
      end
    end
  end

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(posedge forever_cpuclk);
      #2;
      if (sb_q.size() == 0 && !resp_busy) done = 1'b1;
    end
    checkOutput("drain", 32'(done), 32'd1);
    if (!done) sb_q.delete();
  endtask

  task automatic applyStimulus(input logic [31:0] a, input bit wr, input bit sv, input bit dn,
                               input bit db, input int dly, input logic [31:0] dat, input bit no_wait);
    bit                 granted;
    logic [NUM_SLV-1:0] es;
    if (!no_wait) begin
      @(posedge forever_cpuclk);
      #1;
    end
    bmu_tcipif_dbus_addr      = a;
    bmu_tcipif_dbus_write     = wr;
    bmu_tcipif_dbus_size      = 2'($urandom);
    bmu_tcipif_dbus_wdata     = $urandom;
    bmu_tcipif_dbus_supv_mode = sv;
    bmu_tcipif_dbus_acc_deny  = dn;
    rtu_yy_xx_dbgon           = db;
    resp_delay                = dly;
    resp_data                 = dat;
    bmu_tcipif_dbus_req       = 1'b1;
    granted = 1'b0;
    for (int t = 0; t < 8 && !granted; t++) begin
      @(negedge forever_cpuclk);
      if (tcipif_bmu_dbus_grnt) granted = 1'b1;
      else begin
        @(posedge forever_cpuclk);
        #1;
      end
    end
    checkOutput("grnt", 32'(granted), 32'd1);
    if (granted) begin
      modelExpect(cyc, es);
      @(posedge forever_cpuclk);
      #1;
      bmu_tcipif_dbus_req = 1'b0;
      checkOutput("sel", 32'(tcipif_slv_sel), 32'(es));
      if (es != '0) begin
        checkOutput("xx_addr", 32'(tcipif_xx_addr), 32'(a[15:0]));
        checkOutput("xx_write", 32'(tcipif_xx_write), 32'(wr));
        checkOutput("xx_size", 32'(tcipif_xx_size), 32'(bmu_tcipif_dbus_size));
        checkOutput("xx_wdata", tcipif_xx_wdata, bmu_tcipif_dbus_wdata);
      end
      waitDrain();
    end else begin
      bmu_tcipif_dbus_req = 1'b0;
    end
  endtask

  // Request stays high through BUSY: no grant until the cycle after the slave completes.
  task automatic holdTest(input logic [31:0] a, input int dly, input logic [31:0] dat);
    logic [NUM_SLV-1:0] es;
    @(posedge forever_cpuclk);
    #1;
    bmu_tcipif_dbus_addr      = a;
    bmu_tcipif_dbus_write     = 1'b0;
    bmu_tcipif_dbus_supv_mode = 1'b1;
    bmu_tcipif_dbus_acc_deny  = 1'b0;
    rtu_yy_xx_dbgon           = 1'b0;
    resp_delay                = dly;
    resp_data                 = dat;
    bmu_tcipif_dbus_req       = 1'b1;
    @(negedge forever_cpuclk);
    checkOutput("hold_grnt1", 32'(tcipif_bmu_dbus_grnt), 32'd1);
    modelExpect(cyc, es);
    checkOutput("hold_sel_model", 32'(es), 32'h2);
    for (int k = 1; k <= dly; k++) begin
      @(negedge forever_cpuclk);
      checkOutput("hold_no_grnt", 32'(tcipif_bmu_dbus_grnt), 32'd0);
      if (k == 1) checkOutput("hold_sel", 32'(tcipif_slv_sel), 32'h2);
    end
    @(negedge forever_cpuclk);
    checkOutput("hold_grnt2", 32'(tcipif_bmu_dbus_grnt), 32'd1);
    if (tcipif_bmu_dbus_grnt) modelExpect(cyc, es);
    @(posedge forever_cpuclk);
    #1;
    bmu_tcipif_dbus_req = 1'b0;
    waitDrain();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [15:0] w;
    logic [3:0]  rgn;

    pad_cpu_tcip_base         = 32'hE000_0000;
    slv_win_base              = {16'h0800, 16'h0012, 16'h0010, 16'h0000};
    slv_win_mask              = {16'hFF00, 16'hFFFF, 16'hFFF0, 16'hFFFF};
    slv_user_en               = '0;
    bmu_tcipif_dbus_req       = 1'b0;
    bmu_tcipif_dbus_addr      = '0;
    bmu_tcipif_dbus_write     = 1'b0;
    bmu_tcipif_dbus_size      = '0;
    bmu_tcipif_dbus_wdata     = '0;
    bmu_tcipif_dbus_supv_mode = 1'b0;
    bmu_tcipif_dbus_acc_deny  = 1'b0;
    rtu_yy_xx_dbgon           = 1'b0;

    repeat (2) @(posedge forever_cpuclk);
    @(negedge forever_cpuclk);
    checkOutput("rst_sel", 32'(tcipif_slv_sel), 32'd0);
    checkOutput("rst_xx_addr", 32'(tcipif_xx_addr), 32'd0);
    checkOutput("rst_xx_write", 32'(tcipif_xx_write), 32'd0);
    checkOutput("rst_xx_size", 32'(tcipif_xx_size), 32'd0);
    checkOutput("rst_xx_wdata", tcipif_xx_wdata, 32'd0);
    checkOutput("rst_grnt", 32'(tcipif_bmu_dbus_grnt), 32'd0);
    checkOutput("rst_cmplt", 32'(tcipif_bmu_dbus_trans_cmplt), 32'd0);
    checkOutput("rst_err", 32'(tcipif_bmu_dbus_acc_err), 32'd0);
    @(posedge forever_cpuclk);
    #1;
    cpurst_b = 1'b1;

    $display("[TB] directed transactions");
    applyStimulus(32'hE000_0004, 1'b0, 1'b1, 1'b0, 1'b0, 3, 32'hA5A5_0001, 1'b0);
    applyStimulus(32'hE001_0008, 1'b1, 1'b0, 1'b0, 1'b0, 2, 32'h1111_2222, 1'b0);
    applyStimulus(32'hE001_0008, 1'b1, 1'b0, 1'b0, 1'b1, 2, 32'h1234_5678, 1'b0);
    slv_user_en = 4'b0010;
    applyStimulus(32'hE001_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1, 32'hCAFE_0002, 1'b0);
    applyStimulus(32'hE000_0004, 1'b0, 1'b1, 1'b1, 1'b1, 2, 32'h0BAD_0003, 1'b0);
    applyStimulus(32'hE123_4000, 1'b0, 1'b1, 1'b0, 1'b0, 2, 32'h0BAD_0004, 1'b0);
    applyStimulus(32'hD000_0004, 1'b1, 1'b1, 1'b0, 1'b0, 2, 32'h0BAD_0005, 1'b0);
    applyStimulus(32'hE080_0ABC, 1'b0, 1'b1, 1'b0, 1'b0, TIMEOUT, 32'h5EED_000F, 1'b0);
    applyStimulus(32'hE080_0ABC, 1'b0, 1'b1, 1'b0, 1'b0, TIMEOUT + 1, 32'h0BAD_0010, 1'b0);
    applyStimulus(32'hE000_0100, 1'b0, 1'b1, 1'b0, 1'b0, TIMEOUT + 3, 32'h0BAD_0012, 1'b0);
    holdTest(32'hE001_2000, 4, 32'h0F0F_1234);

    $display("[TB] reset during busy");
    @(posedge forever_cpuclk);
    #1;
    bmu_tcipif_dbus_addr      = 32'hE000_0020;
    bmu_tcipif_dbus_supv_mode = 1'b1;
    bmu_tcipif_dbus_acc_deny  = 1'b0;
    resp_delay                = 40;
    bmu_tcipif_dbus_req       = 1'b1;
    @(negedge forever_cpuclk);
    checkOutput("rst_pre_grnt", 32'(tcipif_bmu_dbus_grnt), 32'd1);
    @(posedge forever_cpuclk);
    #1;
    bmu_tcipif_dbus_req = 1'b0;
    checkOutput("rst_pre_sel", 32'(tcipif_slv_sel), 32'h1);
    @(posedge forever_cpuclk);
    #1;
    cpurst_b = 1'b0;
    #1;
    checkOutput("rst_mid_sel", 32'(tcipif_slv_sel), 32'd0);
    checkOutput("rst_mid_cmplt", 32'(tcipif_bmu_dbus_trans_cmplt), 32'd0);
    repeat (2) @(posedge forever_cpuclk);
    #1;
    cpurst_b = 1'b1;
    applyStimulus(32'hE000_0040, 1'b0, 1'b1, 1'b0, 1'b0, 2, 32'h7777_0040, 1'b1);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0:       w = 16'h0000;
        1:       w = {12'h001, 4'($urandom)};
        2:       w = 16'h0012;
        3:       w = {8'h08, 8'($urandom)};
        default: w = 16'($urandom);
      endcase
      rgn = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hE;
      a = {rgn, w, 12'($urandom)};
      slv_user_en = 4'($urandom);
      applyStimulus(a, 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 4) == 0), $urandom_range(1, TIMEOUT + 3), $urandom, 1'b0);
    end

    repeat (3) @(posedge forever_cpuclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
